// File: rtl/wb_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_pkg
// Description : Shared types and constants for the Wishbone burst master:
//               FSM state encoding, byte-select constant, address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_PUSH  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0]  SEL_ALL   = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;

    // Byte address -> word-aligned byte address.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_master
// Description : Wishbone classic initiator. Converts one burst command into
//               back-to-back single-word WB transactions; write data comes
//               from a valid/ready stream, read data goes out on a
//               valid/ready stream. A per-word timeout aborts the burst if
//               the responder never acks.
// Ports       : clk/rst              - clock, async active-high reset
//               cmd_*                - burst command handshake
//               wr_*                 - write-data stream (sink)
//               rd_*                 - read-data stream (source)
//               busy/done/err        - burst status
//               wbm_*                - Wishbone classic master port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_master #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);
    import wb_burst_pkg::*;

    localparam int             TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  C_TMAX = TW'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic [31:0]        r_rdat;
    logic [LEN_W-1:0]   r_rem;
    logic [TW-1:0]      r_tcnt;
    logic [3:0]         r_sel;
    logic               r_err;

    logic               w_accept;
    logic               w_last;
    logic               w_advance;
    logic               w_timeout;
    logic               w_capture;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        w_timeout = 1'b0;
        w_capture = 1'b0;
        w_last    = (r_rem == LEN_W'(1));
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_len == '0) begin
                        w_next = ST_DONE;
                    end else if (cmd_write) begin
                        w_next = ST_FETCH;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
            end
            ST_FETCH: begin
                if (wr_valid) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // ack takes priority over an expiring timeout
                if (wbm_ack_i) begin
                    if (!r_we) begin
                        w_capture = 1'b1;
                        w_next    = ST_PUSH;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = w_last ? ST_DONE : ST_GAP;
                    end
                end else if (r_tcnt == C_TMAX) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (rd_ready) begin
                    w_advance = 1'b1;
                    w_next    = w_last ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP: begin
                // stb must drop for one cycle between words
                w_next = r_we ? ST_FETCH : ST_REQ;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_adr  <= '0;
            r_dat  <= '0;
            r_rdat <= '0;
            r_rem  <= '0;
            r_tcnt <= '0;
            r_sel  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;

            if (w_accept) begin
                r_we  <= cmd_write;
                r_adr <= word_align(cmd_addr);
                r_rem <= cmd_len;
            end

            if (r_state == ST_FETCH && wr_valid) begin
                r_dat <= wr_data;
            end

            if (w_capture) begin
                r_rdat <= wbm_dat_i;
            end

            if (w_advance) begin
                r_adr <= r_adr + ADDR_STEP;
                r_rem <= r_rem - LEN_W'(1);
            end

            // select is zero out of reset and becomes all-ones from the
            // first strobe onwards, already valid in the first REQ cycle
            if (w_next == ST_REQ) begin
                r_sel <= SEL_ALL;
            end

            if (r_state == ST_REQ) begin
                r_tcnt <= r_tcnt + TW'(1);
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: control outputs decode the state register so an async
    // reset drops cyc/stb without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign cmd_ready = (r_state == ST_IDLE);
    assign wr_ready  = (r_state == ST_FETCH);
    assign rd_valid  = (r_state == ST_PUSH);
    assign rd_data   = r_rdat;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign wbm_cyc_o = (r_state == ST_FETCH) || (r_state == ST_REQ) ||
                       (r_state == ST_PUSH)  || (r_state == ST_GAP);
    assign wbm_stb_o = (r_state == ST_REQ);
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wb_burst_master
// Description : Self-checking bench for wb_burst_master. A 10-cycle-latency
//               Wishbone responder (16-word memory, indexed by adr[5:2]) and
//               a scoreboard of expected strobes and read words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_burst_master;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic             busy, done, err;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat_o;
    logic [31:0]      dat_i = '0;
    logic             ack = 1'b0;

    wb_burst_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .err(err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [31:0] wr_src_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] resp_mem  [16];

    int vectors = 0, miscompares = 0;
    int stb_pulses = 0, stb_cycles = 0, done_cnt = 0, err_cnt = 0;
    int resp_cnt = 0;
    bit ack_en = 1'b1;
    bit wr_pop = 1'b0;
    logic prev_stb = 1'b0;
    xfer_t e_mon;
    logic [31:0] junk, rexp;

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            resp_mem[i]  = '0;
        end
    end

    // Responder, write-stream source and scoreboard monitor (negedge).
    always @(negedge clk) begin
        if (rst) begin
            ack      = 1'b0;
            resp_cnt = 0;
            wr_pop   = 1'b0;
            prev_stb = 1'b0;
        end else begin
            if (wr_pop && wr_src_q.size() > 0) junk = wr_src_q.pop_front();
            wr_valid = (wr_src_q.size() > 0);
            wr_data  = (wr_src_q.size() > 0) ? wr_src_q[0] : 32'h0;
            wr_pop   = wr_valid && wr_ready;

            if (stb)  stb_cycles++;
            if (done) done_cnt++;
            if (err)  err_cnt++;

            if (stb && !prev_stb) begin
                stb_pulses++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stb_unexpected got adr=%h we=%b, none expected", adr, we);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (adr !== e_mon.adr || we !== e_mon.we || sel !== 4'hF ||
                        (e_mon.we && dat_o !== e_mon.dat)) begin
                        miscompares++;
                        $display("FAIL stb_xfer got adr=%h we=%b sel=%h dat=%h expected adr=%h we=%b sel=f dat=%h",
                                 adr, we, sel, dat_o, e_mon.adr, e_mon.we, e_mon.dat);
                    end
                end
            end
            prev_stb = stb;

            if (rd_valid && rd_ready) begin
                vectors++;
                if (rd_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected got data=%h, none expected", rd_data);
                end else begin
                    rexp = rd_exp_q.pop_front();
                    if (rd_data !== rexp) begin
                        miscompares++;
                        $display("FAIL rd_data got=%h expected=%h", rd_data, rexp);
                    end
                end
            end

            if (ack) begin
                ack      = 1'b0;
                resp_cnt = 0;
            end else if (cyc && stb) begin
                resp_cnt++;
                if (ack_en && resp_cnt >= LAT) begin
                    ack = 1'b1;
                    if (we) resp_mem[adr[5:2]] = dat_o;
                    else    dat_i = resp_mem[adr[5:2]];
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle and queue the expected traffic.
    task automatic issue(input logic w, input logic [31:0] a, input int n);
        logic [31:0] wa;
        xfer_t x;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = n[LEN_W-1:0];
        cmd_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wa    = (a & 32'hFFFF_FFFC) + 32'(4 * i);
            x.adr = wa;
            x.we  = w;
            if (w) begin
                x.dat = $urandom;
                wr_src_q.push_back(x.dat);
                model_mem[wa[5:2]] = x.dat;
            end else begin
                x.dat = model_mem[wa[5:2]];
                rd_exp_q.push_back(x.dat);
            end
            exp_q.push_back(x);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status got rdy=%b busy=%b done=%b err=%b expected 1 0 0 0",
                     cmd_ready, busy, done, err);
        end
        vectors++;
        if (cyc !== 1'b0 || stb !== 1'b0 || sel !== 4'h0 || adr !== 32'h0 ||
            wr_ready !== 1'b0 || rd_valid !== 1'b0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wb got cyc=%b stb=%b sel=%h adr=%h wrdy=%b rvld=%b we=%b expected all 0",
                     cyc, stb, sel, adr, wr_ready, rd_valid, we);
        end
    endtask

    task automatic test_write_burst();
        int bp, bd;
        bit ok;
        bp = stb_pulses;
        bd = done_cnt;
        issue(1'b1, 32'h3800_0000, 4);
        wait_idle(300, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wr_burst_idle got busy=%b expected 0", busy); end
        tick();
        vectors++;
        if (stb_pulses - bp !== 4) begin
            miscompares++; $display("FAIL wr_burst_pulses got=%0d expected=4", stb_pulses - bp);
        end
        vectors++;
        if (done_cnt - bd !== 1) begin
            miscompares++; $display("FAIL wr_burst_done got=%0d expected=1", done_cnt - bd);
        end
        vectors++;
        if (busy !== 1'b0 || cyc !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wr_burst_end got busy=%b cyc=%b pending=%0d expected 0 0 0", busy, cyc, exp_q.size());
        end
    endtask

    task automatic test_read_burst();
        int bp, bd;
        bit ok, got;
        bp = stb_pulses;
        bd = done_cnt;
        rd_ready = 1'b0;
        issue(1'b0, 32'h3800_0000, 3);
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (rd_valid) begin got = 1'b1; break; end
                tick();
            end
            vectors++;
            if (!got) begin miscompares++; $display("FAIL rd_valid_wait word=%0d got=0 expected=1", k); end
            if (k == 1) begin
                for (int j = 0; j < 5; j++) begin
                    vectors++;
                    if (rd_valid !== 1'b1 || rd_data !== model_mem[1] || stb !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rd_stall got vld=%b data=%h stb=%b expected 1 %h 0",
                                 rd_valid, rd_data, stb, model_mem[1]);
                    end
                    tick();
                end
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        wait_idle(100, ok);
        tick();
        vectors++;
        if (!ok || stb_pulses - bp !== 3 || done_cnt - bd !== 1) begin
            miscompares++;
            $display("FAIL rd_burst_end got idle=%b pulses=%0d done=%0d expected 1 3 1", ok, stb_pulses - bp, done_cnt - bd);
        end
        vectors++;
        if (rd_exp_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_burst_pending got rd=%0d stb=%0d expected 0 0", rd_exp_q.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int bc, be, bd;
        bit seen;
        ack_en = 1'b0;
        bc = stb_cycles;
        be = err_cnt;
        bd = done_cnt;
        issue(1'b0, 32'h3800_0010, 1);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (err) begin seen = 1'b1; break; end
            tick();
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL timeout_err got=0 expected=1"); end
        vectors++;
        if (cyc !== 1'b0 || stb !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_state got cyc=%b stb=%b rdy=%b expected 0 0 1", cyc, stb, cmd_ready);
        end
        tick();
        tick();
        vectors++;
        if (stb_cycles - bc !== TIMEOUT) begin
            miscompares++; $display("FAIL timeout_stb_len got=%0d expected=%0d", stb_cycles - bc, TIMEOUT);
        end
        vectors++;
        if (err_cnt - be !== 1 || done_cnt - bd !== 0) begin
            miscompares++;
            $display("FAIL timeout_pulses got err=%0d done=%0d expected 1 0", err_cnt - be, done_cnt - bd);
        end
        rd_exp_q.delete();
        ack_en = 1'b1;
    endtask

    task automatic test_zero_len();
        int bp, bd;
        bp = stb_pulses;
        bd = done_cnt;
        issue(1'b1, 32'h3800_0000, 0);
        vectors++;
        if (done !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0) begin
            miscompares++; $display("FAIL zero_len_done got done=%b cyc=%b stb=%b expected 1 0 0", done, cyc, stb);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || cyc !== 1'b0) begin
            miscompares++; $display("FAIL zero_len_after got done=%b busy=%b cyc=%b expected 0 0 0", done, busy, cyc);
        end
        tick();
        vectors++;
        if (stb_pulses - bp !== 0 || done_cnt - bd !== 1) begin
            miscompares++;
            $display("FAIL zero_len_counts got pulses=%0d done=%0d expected 0 1", stb_pulses - bp, done_cnt - bd);
        end
    endtask

    task automatic test_async_reset();
        int bp, bd, be;
        bit ok, got;
        rd_ready = 1'b1;
        bp = stb_pulses;
        bd = done_cnt;
        be = err_cnt;
        issue(1'b0, 32'h3800_0000, 3);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (stb_pulses - bp == 2 && stb) begin got = 1'b1; break; end
            tick();
        end
        vectors++;
        if (!got) begin miscompares++; $display("FAIL arst_reach_word2 got=0 expected=1"); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL arst_drop got cyc=%b stb=%b busy=%b expected 0 0 0", cyc, stb, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        rd_exp_q.delete();
        repeat (3) tick();
        vectors++;
        if (done_cnt - bd !== 0 || err_cnt - be !== 0 || sel !== 4'h0) begin
            miscompares++;
            $display("FAIL arst_quiet got done=%0d err=%0d sel=%h expected 0 0 0", done_cnt - bd, err_cnt - be, sel);
        end
        rd_ready = 1'b0;
        issue(1'b1, 32'h3800_0020, 2);
        wait_idle(100, ok);
        tick();
        vectors++;
        if (!ok || done_cnt - bd !== 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL arst_next_cmd got idle=%b done=%0d pending=%0d expected 1 1 0", ok, done_cnt - bd, exp_q.size());
        end
    endtask

    task automatic test_addr_wrap();
        int bd;
        bit ok;
        bd = done_cnt;
        issue(1'b1, 32'hFFFF_FFFC, 2);
        wait_idle(100, ok);
        tick();
        rd_ready = 1'b1;
        issue(1'b0, 32'h3800_0003, 1);
        wait_idle(100, ok);
        tick();
        rd_ready = 1'b0;
        vectors++;
        if (!ok || done_cnt - bd !== 2 || exp_q.size() != 0 || rd_exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL addr_wrap_end got idle=%b done=%0d stb_pend=%0d rd_pend=%0d expected 1 2 0 0",
                     ok, done_cnt - bd, exp_q.size(), rd_exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_timeout();
        test_zero_len();
        test_async_reset();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
